axi4_slave_mem_responder: RTL and testbench
===========================================

// Module: axi4_slave_mem_responder
// PURPOSE: Synthesizable AXI4 slave responder: the memory side of the accelerator's io_M_AXI_0 master port.
//   Accepts AW/W/AR bursts and returns B/R from an internal word-addressed RAM, for system sims and on-board loopback.
//   Instantiated in place of the DRAM controller; independent read and write engines, one outstanding burst each.
// PARAMETERS:
//   DATA_W      512  data bus width; one beat = DATA_W/8 bytes (64 B); only full-width INCR bursts supported
//   ID_W        6    AXI ID width, echoed unchanged on BID/RID
//   DEPTH_LOG2  10   RAM holds 2^DEPTH_LOG2 words of DATA_W bits
//   RD_LATENCY  2    cycles from AR handshake edge to first RVALID (legal 1..8)
// PORTS:
//   clock              in   1        single clock, all logic rising-edge
//   reset              in   1        asynchronous, active-low (0 = reset asserted)
//   io_S_AXI_AWID      in   ID_W     write burst ID
//   io_S_AXI_AWADDR    in   32       write byte address; bits [5:0] ignored
//   io_S_AXI_AWLEN     in   8        beats-1
//   io_S_AXI_AWVALID   in   1        AW valid
//   io_S_AXI_AWREADY   out  1        AW ready
//   io_S_AXI_WDATA     in   DATA_W   write data
//   io_S_AXI_WSTRB     in   DATA_W/8 byte enables
//   io_S_AXI_WLAST     in   1        last write beat
//   io_S_AXI_WVALID    in   1        W valid
//   io_S_AXI_WREADY    out  1        W ready
//   io_S_AXI_BID       out  ID_W     = accepted AWID
//   io_S_AXI_BRESP     out  2        00 OKAY, 10 SLVERR
//   io_S_AXI_BVALID    out  1        B valid
//   io_S_AXI_BREADY    in   1        B ready
//   io_S_AXI_ARID      in   ID_W     read burst ID
//   io_S_AXI_ARADDR    in   32       read byte address; bits [5:0] ignored
//   io_S_AXI_ARLEN     in   8        beats-1
//   io_S_AXI_ARVALID   in   1        AR valid
//   io_S_AXI_ARREADY   out  1        AR ready
//   io_S_AXI_RID       out  ID_W     = accepted ARID
//   io_S_AXI_RDATA     out  DATA_W   read data
//   io_S_AXI_RRESP     out  2        00 OKAY, 10 SLVERR
//   io_S_AXI_RLAST     out  1        last read beat
//   io_S_AXI_RVALID    out  1        R valid
//   io_S_AXI_RREADY    in   1        R ready
// BEHAVIOUR:
// - Reset: all VALID/READY, BID/RID, RESP, RLAST, RDATA = 0; both FSMs -> IDLE; RAM contents NOT cleared; mid-burst reset abandons burst silently.
// - Word index = ADDR[DEPTH_LOG2+5:6], +1 per beat, wraps modulo 2^DEPTH_LOG2. ADDR[31:DEPTH_LOG2+6] != 0 -> burst out of range.
// - Write FSM W_IDLE -> W_DATA -> W_RESP. AWREADY=1 only in W_IDLE; handshake latches ID/index/len, -> W_DATA.
//   W_DATA: WREADY=1; each WVALID&WREADY writes bytes with WSTRB=1; on WLAST -> W_RESP. Out-of-range: beats accepted, dropped.
//   W_RESP: BVALID=1 held with BID/BRESP stable until BREADY; then W_IDLE (AWREADY back next cycle).
//   BRESP=SLVERR if out of range or WLAST beat count != AWLEN+1 (burst always ends on WLAST).
// - Read FSM R_IDLE -> R_WAIT -> R_DATA. ARREADY=1 only in R_IDLE; handshake latches ID/index/len.
//   R_WAIT: RD_LATENCY-1 cycles; first RVALID on cycle RD_LATENCY after handshake edge.
//   R_DATA: RVALID, RDATA, RLAST held stable until RREADY; with RREADY held high, one beat per cycle (prefetch/skid, no bubbles).
//   RLAST=1 on beat ARLEN only; after that handshake -> R_IDLE. Out-of-range: RDATA=0, RRESP=SLVERR all beats.
// - Simultaneous write and read to same word same cycle: read returns pre-write data. Read/write engines never stall each other.
// - Handshakes are AXI-compliant: no VALID depends combinationally on READY; AWREADY/ARREADY may be high before VALID.
// TESTING:
// 1 Reset: hold reset=0 mid-R_DATA with RVALID=1 -> all outputs 0 async; release -> AWREADY=ARREADY=1 next edge, RAM intact.
// 2 AW addr 0x40 len 3, 4 beats data k, WSTRB all 1, BREADY=1 -> BVALID once, BRESP=00, BID=AWID; AR 0x40 len 3 -> 4 beats data 0..3, RLAST beat 3.
// 3 Strobe: word 5 = all-1s, write 0 with WSTRB=0x1 -> readback byte0=0x00, other 63 bytes 0xFF.
// 4 Backpressure: read len 7, RREADY toggling 1/0 -> RDATA/RLAST stable while stalled, 8 beats in order, no duplicates/drops; RREADY=1 -> 8 consecutive cycles.
// 5 Errors: AWADDR=0x8000_0000 -> BRESP=10, RAM unchanged; AWLEN=3 with WLAST on beat 1 -> BRESP=10 after 2 beats; AR out of range -> RDATA=0, RRESP=10.
// 6 Wrap/concurrency: write len 1 at word 1023 -> words 1023,0 written; concurrent AR/AW bursts both complete, BID/RID match own IDs.

Source files
------------

// File: rtl/axi4_slave_mem_responder.sv
// axi4_slave_mem_responder
//   AXI4 slave that stands in for the DRAM controller behind io_M_AXI_0.
//   Serves full-width INCR bursts from an internal word-addressed RAM of
//   2^DEPTH_LOG2 words. Independent write and read engines, one outstanding
//   burst each. Addresses with bits above the RAM window set are answered
//   with SLVERR (writes dropped, reads return zero).
// Ports:
//   clock, reset        single rising-edge clock, async active-low reset
//   io_S_AXI_AW*        write address channel (ID, byte address, length)
//   io_S_AXI_W*         write data channel (data, byte strobes, last)
//   io_S_AXI_B*         write response channel (ID echo, response)
//   io_S_AXI_AR*        read address channel (ID, byte address, length)
//   io_S_AXI_R*         read data channel (ID echo, data, response, last)
module axi4_slave_mem_responder #(
   parameter int unsigned DATA_W     = 512,
   parameter int unsigned ID_W       = 6,
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter int unsigned RD_LATENCY = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [ID_W-1:0]     io_S_AXI_AWID,
   input  logic [31:0]         io_S_AXI_AWADDR,
   input  logic [7:0]          io_S_AXI_AWLEN,
   input  logic                io_S_AXI_AWVALID,
   output logic                io_S_AXI_AWREADY,
   input  logic [DATA_W-1:0]   io_S_AXI_WDATA,
   input  logic [DATA_W/8-1:0] io_S_AXI_WSTRB,
   input  logic                io_S_AXI_WLAST,
   input  logic                io_S_AXI_WVALID,
   output logic                io_S_AXI_WREADY,
   output logic [ID_W-1:0]     io_S_AXI_BID,
   output logic [1:0]          io_S_AXI_BRESP,
   output logic                io_S_AXI_BVALID,
   input  logic                io_S_AXI_BREADY,
   input  logic [ID_W-1:0]     io_S_AXI_ARID,
   input  logic [31:0]         io_S_AXI_ARADDR,
   input  logic [7:0]          io_S_AXI_ARLEN,
   input  logic                io_S_AXI_ARVALID,
   output logic                io_S_AXI_ARREADY,
   output logic [ID_W-1:0]     io_S_AXI_RID,
   output logic [DATA_W-1:0]   io_S_AXI_RDATA,
   output logic [1:0]          io_S_AXI_RRESP,
   output logic                io_S_AXI_RLAST,
   output logic                io_S_AXI_RVALID,
   input  logic                io_S_AXI_RREADY
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned WAIT_W = 3;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

   logic [DATA_W-1:0] mem [0:(1 << DEPTH_LOG2) - 1];

   // Byte offset within a beat carries no information for full-width bursts.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{io_S_AXI_AWADDR[5:0], io_S_AXI_ARADDR[5:0]};

   // ---------------- write engine ----------------
   w_state_e              w_state_q, w_state_d;
   logic [DEPTH_LOG2-1:0] w_idx_q, w_idx_d;
   logic [7:0]            w_len_q, w_len_d;
   logic [8:0]            w_cnt_q, w_cnt_d;
   logic                  w_oor_q, w_oor_d;
   logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic [ID_W-1:0]       bid_q, bid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  mem_we;

   always_comb begin
      w_state_d = w_state_q;
      w_idx_d   = w_idx_q;
      w_len_d   = w_len_q;
      w_cnt_d   = w_cnt_q;
      w_oor_d   = w_oor_q;
      bid_d     = bid_q;
      bresp_d   = bresp_q;
      mem_we    = 1'b0;
      case (w_state_q)
         W_IDLE: if (io_S_AXI_AWVALID && awready_q) begin
            bid_d     = io_S_AXI_AWID;
            w_idx_d   = io_S_AXI_AWADDR[DEPTH_LOG2+5:6];
            w_len_d   = io_S_AXI_AWLEN;
            w_oor_d   = |io_S_AXI_AWADDR[31:DEPTH_LOG2+6];
            w_cnt_d   = '0;
            w_state_d = W_DATA;
         end
         W_DATA: if (io_S_AXI_WVALID && wready_q) begin
            mem_we  = !w_oor_q;
            w_idx_d = w_idx_q + DEPTH_LOG2'(1);
            w_cnt_d = w_cnt_q + 9'd1;
            if (io_S_AXI_WLAST) begin
               // w_cnt_q counts beats before this one, so a correct burst ends with w_cnt_q == AWLEN
               bresp_d   = (w_oor_q || (w_cnt_q != {1'b0, w_len_q})) ? 2'b10 : 2'b00;
               w_state_d = W_RESP;
            end
         end
         W_RESP: if (io_S_AXI_BREADY) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
      // Handshake outputs are registered copies of the next state.
      awready_d = (w_state_d == W_IDLE);
      wready_d  = (w_state_d == W_DATA);
      bvalid_d  = (w_state_d == W_RESP);
   end

   // ---------------- read engine ----------------
   r_state_e              r_state_q, r_state_d;
   logic [DEPTH_LOG2-1:0] r_idx_q, r_idx_d;
   logic [7:0]            r_len_q, r_len_d;
   logic [7:0]            r_beat_q, r_beat_d;
   logic [WAIT_W-1:0]     r_wait_q, r_wait_d;
   logic                  r_oor_q, r_oor_d;
   logic                  r_load;
   logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
   logic [ID_W-1:0]       rid_q, rid_d;
   logic [DATA_W-1:0]     rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;

   always_comb begin
      r_state_d = r_state_q;
      r_idx_d   = r_idx_q;
      r_len_d   = r_len_q;
      r_beat_d  = r_beat_q;
      r_wait_d  = r_wait_q;
      r_oor_d   = r_oor_q;
      rid_d     = rid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rlast_d   = rlast_q;
      r_load    = 1'b0;
      case (r_state_q)
         R_IDLE: if (io_S_AXI_ARVALID && arready_q) begin
            rid_d     = io_S_AXI_ARID;
            r_idx_d   = io_S_AXI_ARADDR[DEPTH_LOG2+5:6];
            r_len_d   = io_S_AXI_ARLEN;
            r_oor_d   = |io_S_AXI_ARADDR[31:DEPTH_LOG2+6];
            r_beat_d  = '0;
            r_wait_d  = WAIT_W'(RD_LATENCY - 1);
            r_state_d = R_WAIT;
         end
         R_WAIT: begin
            if (r_wait_q == '0) r_load = 1'b1;
            else                r_wait_d = r_wait_q - WAIT_W'(1);
         end
         R_DATA: if (io_S_AXI_RREADY) begin
            if (rlast_q) begin
               rlast_d   = 1'b0;
               r_state_d = R_IDLE;
            end else begin
               r_load = 1'b1;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      // Output register reloads straight from the RAM on the accepting edge,
      // so back-to-back beats need no bubble and stalls simply hold it.
      if (r_load) begin
         rdata_d   = r_oor_q ? '0 : mem[r_idx_q];
         rresp_d   = r_oor_q ? 2'b10 : 2'b00;
         rlast_d   = (r_beat_q == r_len_q);
         r_idx_d   = r_idx_q + DEPTH_LOG2'(1);
         r_beat_d  = r_beat_q + 8'd1;
         r_state_d = R_DATA;
      end
      arready_d = (r_state_d == R_IDLE);
      rvalid_d  = (r_state_d == R_DATA);
   end

   // ---------------- state registers ----------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         w_state_q <= W_IDLE;
         w_idx_q   <= '0;
         w_len_q   <= '0;
         w_cnt_q   <= '0;
         w_oor_q   <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bid_q     <= '0;
         bresp_q   <= '0;
         r_state_q <= R_IDLE;
         r_idx_q   <= '0;
         r_len_q   <= '0;
         r_beat_q  <= '0;
         r_wait_q  <= '0;
         r_oor_q   <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rid_q     <= '0;
         rdata_q   <= '0;
         rresp_q   <= '0;
      end else begin
         w_state_q <= w_state_d;
         w_idx_q   <= w_idx_d;
         w_len_q   <= w_len_d;
         w_cnt_q   <= w_cnt_d;
         w_oor_q   <= w_oor_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bid_q     <= bid_d;
         bresp_q   <= bresp_d;
         r_state_q <= r_state_d;
         r_idx_q   <= r_idx_d;
         r_len_q   <= r_len_d;
         r_beat_q  <= r_beat_d;
         r_wait_q  <= r_wait_d;
         r_oor_q   <= r_oor_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         rid_q     <= rid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   // RAM is deliberately not reset; contents survive a reset pulse.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         for (int unsigned b = 0; b < STRB_W; b++) begin
            if (io_S_AXI_WSTRB[b]) mem[w_idx_q][b*8 +: 8] <= io_S_AXI_WDATA[b*8 +: 8];
         end
      end
   end

   assign io_S_AXI_AWREADY = awready_q;
   assign io_S_AXI_WREADY  = wready_q;
   assign io_S_AXI_BID     = bid_q;
   assign io_S_AXI_BRESP   = bresp_q;
   assign io_S_AXI_BVALID  = bvalid_q;
   assign io_S_AXI_ARREADY = arready_q;
   assign io_S_AXI_RID     = rid_q;
   assign io_S_AXI_RDATA   = rdata_q;
   assign io_S_AXI_RRESP   = rresp_q;
   assign io_S_AXI_RLAST   = rlast_q;
   assign io_S_AXI_RVALID  = rvalid_q;

endmodule

// File: tb/tb_axi4_slave_mem_responder.sv
// tb_axi4_slave_mem_responder
//   Directed bench for axi4_slave_mem_responder: write and read burst tables
//   with hand-computed expectations, plus hand-written sequences for byte
//   strobes, read backpressure, concurrent bursts and mid-burst reset.
module tb_axi4_slave_mem_responder;

   localparam int DATA_W     = 512;
   localparam int ID_W       = 6;
   localparam int DEPTH_LOG2 = 10;
   localparam int RD_LATENCY = 2;

   logic              clock = 1'b0;
   logic              reset;
   logic [ID_W-1:0]   awid, arid, bid, rid;
   logic [31:0]       awaddr, araddr;
   logic [7:0]        awlen, arlen;
   logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [DATA_W-1:0] wdata, rdata;
   logic [63:0]       wstrb;
   logic [1:0]        bresp, rresp;
   logic              arvalid, arready, rlast, rvalid, rready;

   always #5 clock = ~clock;

   axi4_slave_mem_responder #(
      .DATA_W(DATA_W), .ID_W(ID_W), .DEPTH_LOG2(DEPTH_LOG2), .RD_LATENCY(RD_LATENCY)
   ) dut (
      .clock(clock), .reset(reset),
      .io_S_AXI_AWID(awid), .io_S_AXI_AWADDR(awaddr), .io_S_AXI_AWLEN(awlen),
      .io_S_AXI_AWVALID(awvalid), .io_S_AXI_AWREADY(awready),
      .io_S_AXI_WDATA(wdata), .io_S_AXI_WSTRB(wstrb), .io_S_AXI_WLAST(wlast),
      .io_S_AXI_WVALID(wvalid), .io_S_AXI_WREADY(wready),
      .io_S_AXI_BID(bid), .io_S_AXI_BRESP(bresp), .io_S_AXI_BVALID(bvalid),
      .io_S_AXI_BREADY(bready),
      .io_S_AXI_ARID(arid), .io_S_AXI_ARADDR(araddr), .io_S_AXI_ARLEN(arlen),
      .io_S_AXI_ARVALID(arvalid), .io_S_AXI_ARREADY(arready),
      .io_S_AXI_RID(rid), .io_S_AXI_RDATA(rdata), .io_S_AXI_RRESP(rresp),
      .io_S_AXI_RLAST(rlast), .io_S_AXI_RVALID(rvalid), .io_S_AXI_RREADY(rready)
   );

   logic [599:0] outs_vec;
   assign outs_vec = {awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid};

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [599:0] act, input logic [599:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [511:0] rep(input logic [31:0] v);
      return {16{v}};
   endfunction

   function automatic logic [7:0][31:0] seq8(input logic [31:0] b);
      logic [7:0][31:0] r;
      for (int k = 0; k < 8; k++) r[k] = b + 32'(k);
      return r;
   endfunction

   // ---------------- write driver ----------------
   task automatic do_write(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input int last_beat, input logic [31:0] base, input bit use_fixed,
                           input logic [511:0] fixed, input logic [63:0] strb,
                           output logic [1:0] resp, output logic [5:0] bid_o, output int bcnt);
      int t;
      resp = 'x; bid_o = 'x; bcnt = 0;
      bready = 1'b1;
      awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
      t = 0;
      while (!awready && t < 50) begin @(negedge clock); t++; end
      if (!awready) chk("aw_handshake_wait", awready, 1'b1);
      @(negedge clock);
      awvalid = 1'b0;
      for (int k = 0; k <= last_beat; k++) begin
         wdata  = use_fixed ? fixed : rep(base + 32'(k));
         wstrb  = strb;
         wlast  = (k == last_beat);
         wvalid = 1'b1;
         t = 0;
         while (!wready && t < 50) begin @(negedge clock); t++; end
         if (!wready) chk("w_handshake_wait", wready, 1'b1);
         @(negedge clock);
      end
      wvalid = 1'b0; wlast = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (bvalid) begin bcnt++; resp = bresp; bid_o = bid; end
         @(negedge clock);
      end
   endtask

   // ---------------- read driver ----------------
   logic [511:0] got_data [16];
   logic         got_last [16];
   logic [1:0]   got_resp [16];
   logic [5:0]   got_rid;
   int           got_n, first_n, last_n, stall_bad;

   task automatic do_read(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input bit toggle);
      int t;
      bit done, prev_stall;
      logic [511:0] prev_data;
      logic prev_last;
      arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
      t = 0;
      while (!arready && t < 50) begin @(negedge clock); t++; end
      if (!arready) chk("ar_handshake_wait", arready, 1'b1);
      @(negedge clock);
      arvalid = 1'b0;
      got_n = 0; first_n = -1; last_n = -1; stall_bad = 0; got_rid = 'x;
      done = 0; prev_stall = 0; prev_data = '0; prev_last = 1'b0;
      // n counts negedges after the AR handshake edge
      for (int n = 0; n < 200; n++) begin
         rready = toggle ? ((n % 2) == 1) : 1'b1;
         if (prev_stall && (rdata !== prev_data || rlast !== prev_last)) stall_bad++;
         if (rvalid) begin
            if (first_n < 0) first_n = n;
            got_rid = rid;
         end
         if (rvalid && rready) begin
            if (got_n < 16) begin
               got_data[got_n] = rdata;
               got_last[got_n] = rlast;
               got_resp[got_n] = rresp;
            end
            got_n++;
            last_n = n;
            if (rlast) done = 1;
         end
         prev_stall = rvalid && !rready;
         prev_data  = rdata;
         prev_last  = rlast;
         @(negedge clock);
         if (done) break;
      end
      rready = 1'b1;
   endtask

   task automatic check_read(input string tag, input logic [5:0] id, input logic [7:0] len,
                             input logic [7:0][31:0] exp, input logic [1:0] exp_resp);
      chk($sformatf("%s beats", tag), got_n, int'(len) + 1);
      chk($sformatf("%s rid", tag), got_rid, id);
      for (int k = 0; k <= int'(len) && k < 16; k++) begin
         chk($sformatf("%s data%0d", tag, k), got_data[k], rep(exp[k]));
         chk($sformatf("%s last%0d", tag, k), got_last[k], k == int'(len));
         chk($sformatf("%s resp%0d", tag, k), got_resp[k], exp_resp);
      end
   endtask

   typedef struct {
      logic [5:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      int          last_beat;
      logic [31:0] base;
      logic [1:0]  resp;
   } wvec_t;

   typedef struct {
      logic [5:0]       id;
      logic [31:0]      addr;
      logic [7:0]       len;
      logic [7:0][31:0] exp;
      logic [1:0]       resp;
   } rvec_t;

   wvec_t      wv [5];
   rvec_t      rv [6];
   logic [1:0] wr_resp;
   logic [5:0] wr_bid;
   int         wr_bc;
   int         t0;

   initial begin
      wv[0] = '{id: 6'd5, addr: 32'h0000_0040, len: 8'd3, last_beat: 3, base: 32'h0,       resp: 2'b00};
      wv[1] = '{id: 6'd6, addr: 32'h0000_0400, len: 8'd7, last_beat: 7, base: 32'h100,     resp: 2'b00};
      wv[2] = '{id: 6'd7, addr: 32'h0000_FFC0, len: 8'd1, last_beat: 1, base: 32'hA0,      resp: 2'b00};
      wv[3] = '{id: 6'd8, addr: 32'h8000_0000, len: 8'd0, last_beat: 0, base: 32'hDEAD,    resp: 2'b10};
      wv[4] = '{id: 6'd9, addr: 32'h0000_0800, len: 8'd3, last_beat: 1, base: 32'h200,     resp: 2'b10};

      rv[0] = '{id: 6'd10, addr: 32'h0000_0040, len: 8'd3, exp: seq8(32'h0),   resp: 2'b00};
      rv[1] = '{id: 6'd11, addr: 32'h0000_FFC0, len: 8'd1, exp: seq8(32'hA0),  resp: 2'b00};
      rv[2] = '{id: 6'd12, addr: 32'h0000_0000, len: 8'd0, exp: seq8(32'hA1),  resp: 2'b00};
      rv[3] = '{id: 6'd13, addr: 32'h0000_0800, len: 8'd1, exp: seq8(32'h200), resp: 2'b00};
      rv[4] = '{id: 6'd14, addr: 32'h0001_0000, len: 8'd2, exp: '0,            resp: 2'b10};
      rv[5] = '{id: 6'd15, addr: 32'h0000_0400, len: 8'd7, exp: seq8(32'h100), resp: 2'b00};

      reset = 1'b0;
      awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
      arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b1;

      // Reset state
      repeat (2) @(negedge clock);
      chk("reset outputs zero", outs_vec, '0);
      reset = 1'b1;
      chk("awready before release edge", awready, 1'b0);
      @(negedge clock);
      chk("awready after release", awready, 1'b1);
      chk("arready after release", arready, 1'b1);

      // Write bursts
      for (int i = 0; i < 5; i++) begin
         do_write(wv[i].id, wv[i].addr, wv[i].len, wv[i].last_beat, wv[i].base, 1'b0, '0, '1,
                  wr_resp, wr_bid, wr_bc);
         chk($sformatf("W%0d bvalid count", i), wr_bc, 1);
         chk($sformatf("W%0d bresp", i), wr_resp, wv[i].resp);
         chk($sformatf("W%0d bid", i), wr_bid, wv[i].id);
      end

      // Read bursts, RREADY held high: first beat at RD_LATENCY, then one per cycle
      for (int i = 0; i < 6; i++) begin
         do_read(rv[i].id, rv[i].addr, rv[i].len, 1'b0);
         check_read($sformatf("R%0d", i), rv[i].id, rv[i].len, rv[i].exp, rv[i].resp);
         chk($sformatf("R%0d latency", i), first_n, RD_LATENCY);
         chk($sformatf("R%0d consecutive", i), last_n - first_n, int'(rv[i].len));
      end

      // Byte strobe: word 5 all ones, then zero byte 0 only
      do_write(6'd3, 32'h140, 8'd0, 0, 32'h0, 1'b1, '1, '1, wr_resp, wr_bid, wr_bc);
      chk("strobe fill bresp", wr_resp, 2'b00);
      do_write(6'd4, 32'h140, 8'd0, 0, 32'h0, 1'b1, '0, 64'h1, wr_resp, wr_bid, wr_bc);
      chk("strobe byte0 bresp", wr_resp, 2'b00);
      do_read(6'd16, 32'h140, 8'd0, 1'b0);
      chk("strobe readback", got_data[0], {{504{1'b1}}, 8'h00});

      // Backpressure: RREADY toggling
      do_read(6'd17, 32'h400, 8'd7, 1'b1);
      check_read("bp", 6'd17, 8'd7, seq8(32'h100), 2'b00);
      chk("bp stall stability", stall_bad, 0);

      // Concurrent write and read bursts
      fork
         do_write(6'h21, 32'h1000, 8'd3, 3, 32'h300, 1'b0, '0, '1, wr_resp, wr_bid, wr_bc);
         do_read(6'h22, 32'h400, 8'd7, 1'b0);
      join
      chk("conc bid", wr_bid, 6'h21);
      chk("conc bresp", wr_resp, 2'b00);
      check_read("conc rd", 6'h22, 8'd7, seq8(32'h100), 2'b00);
      do_read(6'h23, 32'h1000, 8'd3, 1'b0);
      check_read("conc wr readback", 6'h23, 8'd3, seq8(32'h300), 2'b00);

      // Reset in the middle of a stalled read burst
      arid = 6'h30; araddr = 32'h400; arlen = 8'd7; arvalid = 1'b1; rready = 1'b0;
      t0 = 0;
      while (!arready && t0 < 50) begin @(negedge clock); t0++; end
      @(negedge clock);
      arvalid = 1'b0;
      t0 = 0;
      while (!rvalid && t0 < 20) begin @(negedge clock); t0++; end
      chk("mid-burst rvalid", rvalid, 1'b1);
      reset = 1'b0;
      #1;
      chk("async reset outputs", outs_vec, '0);
      @(negedge clock);
      reset = 1'b1;
      rready = 1'b1;
      @(negedge clock);
      chk("awready after mid reset", awready, 1'b1);
      chk("arready after mid reset", arready, 1'b1);
      do_read(6'h31, 32'h400, 8'd7, 1'b0);
      check_read("ram intact", 6'h31, 8'd7, seq8(32'h100), 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
